// File: rtl/cache_ctrl_2way_pkg.sv
// cache_ctrl_2way_pkg
// Shared definitions for the 2-way set-associative cache controller:
// FSM state encoding, tag-entry layout, index/tag slicing widths, the
// statistics counter limit and the tag-match helper.
package cache_ctrl_2way_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    REFILL    = 2'd2,
    WRITE_MEM = 2'd3
  } state_e;

  localparam int IDX_W         = 3;   // set-index width (8 sets)
  localparam int TAG_W         = 13;  // address tag width
  localparam int TAG_ENTRY_W   = 14;  // {valid, tag}
  localparam int TAG_VALID_BIT = 13;
  localparam int STAT_W        = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  // A way hits when its entry is valid and the stored tag matches.
  function automatic logic tag_hit(input logic [TAG_ENTRY_W-1:0] entry,
                                   input logic [TAG_W-1:0]       tag);
    return entry[TAG_VALID_BIT] && (entry[TAG_W-1:0] == tag);
  endfunction

endpackage

// File: rtl/cache_ctrl_2way_lru.sv
// cache_lru_array
// One LRU bit per set. The bit names the way to evict next.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset (clears all bits)
//   i_idx            : set index for both read and update
//   i_upd_en/i_upd_val : write i_upd_val into bit i_idx on the next edge
//   o_lru            : current LRU bit of set i_idx (combinational read)
module cache_lru_array #(
  parameter int AWIDTH = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [AWIDTH-1:0] i_idx,
  input  logic              i_upd_en,
  input  logic              i_upd_val,
  output logic              o_lru
);

  logic [(1<<AWIDTH)-1:0] r_lru;

  // LRU bit storage with per-set update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lru <= '0;
    end else if (i_upd_en) begin
      r_lru[i_idx] <= i_upd_val;
    end
  end

  assign o_lru = r_lru[i_idx];

endmodule

// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way
// 2-way set-associative, write-through, no-write-allocate cache controller.
// The four cache RAMs (two data ways, two tag ways) are external and share
// ram_addr; their read data appears one cycle after the address.
// Ports:
//   clock, reset                  : rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         : CPU request, held until cpu_ready
//   cpu_ready, cpu_rdata          : one-cycle completion pulse, read data (held)
//   mem_req/we/addr/wdata, mem_ack, mem_rdata : backing-memory handshake
//   ram_addr                      : shared set index for all cache RAMs
//   d0_/d1_ din, we, dout         : data-way RAM ports
//   t0_/t1_ din, we, dout         : tag-way RAM ports ({valid, tag})
//   hit_count, miss_count         : saturating access counters, only when
//                                   the CACHE_STATS_EN macro is defined
module cache_ctrl_2way
  import cache_ctrl_2way_pkg::*;
#(
  parameter int AWIDTH = IDX_W,
  parameter int DWIDTH = 32,
  parameter int TWIDTH = TAG_ENTRY_W,
  parameter int CWIDTH = 16
) (
`ifdef CACHE_STATS_EN
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count,
`endif
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [CWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [CWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] d0_din,
  output logic [DWIDTH-1:0] d1_din,
  output logic              d0_we,
  output logic              d1_we,
  input  logic [DWIDTH-1:0] d0_dout,
  input  logic [DWIDTH-1:0] d1_dout,
  output logic [TWIDTH-1:0] t0_din,
  output logic [TWIDTH-1:0] t1_din,
  output logic              t0_we,
  output logic              t1_we,
  input  logic [TWIDTH-1:0] t0_dout,
  input  logic [TWIDTH-1:0] t1_dout
);

  state_e                     r_state;
  state_e                     w_next_state;
  logic [CWIDTH-1:0]          r_addr;
  logic                       r_we;
  logic [DWIDTH-1:0]          r_wdata;
  logic                       r_cpu_ready;
  logic [DWIDTH-1:0]          r_cpu_rdata;
  logic                       r_mem_req;
  logic                       r_mem_we;
  logic [CWIDTH-1:0]          r_mem_addr;
  logic [DWIDTH-1:0]          r_mem_wdata;

  logic [AWIDTH-1:0]          w_idx;
  logic [CWIDTH-AWIDTH-1:0]   w_tag;
  logic                       w_hit0;
  logic                       w_hit1;
  logic                       w_hit;
  logic                       w_victim;
  logic                       w_lru;
  logic                       w_lru_upd;
  logic                       w_lru_val;

  assign w_idx  = r_addr[AWIDTH-1:0];
  assign w_tag  = r_addr[CWIDTH-1:AWIDTH];
  assign w_hit0 = tag_hit(t0_dout, w_tag);
  assign w_hit1 = tag_hit(t1_dout, w_tag);
  assign w_hit  = w_hit0 | w_hit1;
  // Fill an empty way first (way 0 before way 1), otherwise evict the LRU way.
  assign w_victim = !t0_dout[TAG_VALID_BIT] ? 1'b0 :
                    (!t1_dout[TAG_VALID_BIT] ? 1'b1 : w_lru);

  cache_lru_array #(.AWIDTH(AWIDTH)) u_lru (
    .i_clk     (clock),
    .i_reset   (reset),
    .i_idx     (w_idx),
    .i_upd_en  (w_lru_upd),
    .i_upd_val (w_lru_val),
    .o_lru     (w_lru)
  );

  // Next state, shared RAM index, single-cycle RAM write strobes, LRU update.
  // Way 0 wins a double hit, so the way just used is ~w_hit0 and the LRU
  // bit (the other way) is simply w_hit0.
  always_comb begin
    w_next_state = r_state;
    ram_addr     = w_idx;
    d0_we        = 1'b0;
    d1_we        = 1'b0;
    t0_we        = 1'b0;
    t1_we        = 1'b0;
    d0_din       = r_wdata;
    d1_din       = r_wdata;
    t0_din       = {1'b1, w_tag};
    t1_din       = {1'b1, w_tag};
    w_lru_upd    = 1'b0;
    w_lru_val    = 1'b0;
    if (reset) begin
      // Reset wins over a coincident mem_ack: no RAM write on abort.
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          ram_addr = cpu_addr[AWIDTH-1:0];
          // The request is still high in the cycle cpu_ready is seen; skip it.
          if (cpu_req && !r_cpu_ready) w_next_state = LOOKUP;
          else                         w_next_state = IDLE;
        end
        LOOKUP: begin
          if (r_we) begin
            w_next_state = WRITE_MEM;
            if (w_hit) begin
              d0_we     = w_hit0;
              d1_we     = ~w_hit0;
              w_lru_upd = 1'b1;
              w_lru_val = w_hit0;
            end else begin
              w_lru_upd = 1'b0;
            end
          end else if (w_hit) begin
            w_next_state = IDLE;
            w_lru_upd    = 1'b1;
            w_lru_val    = w_hit0;
          end else begin
            w_next_state = REFILL;
          end
        end
        REFILL: begin
          d0_din = mem_rdata;
          d1_din = mem_rdata;
          if (mem_ack) begin
            w_next_state = IDLE;
            d0_we        = ~w_victim;
            t0_we        = ~w_victim;
            d1_we        = w_victim;
            t1_we        = w_victim;
            w_lru_upd    = 1'b1;
            w_lru_val    = ~w_victim;
          end else begin
            w_next_state = REFILL;
          end
        end
        WRITE_MEM: begin
          if (mem_ack) w_next_state = IDLE;
          else         w_next_state = WRITE_MEM;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State register, request latch and registered CPU/memory outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cpu_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req && !r_cpu_ready) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (r_we) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
          end else if (w_hit) begin
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= w_hit0 ? d0_dout : d1_dout;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_addr;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= mem_rdata;
          end
        end
        WRITE_MEM: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_ready <= 1'b1;
          end
        end
        default: r_cpu_ready <= 1'b0;
      endcase
    end
  end

  assign cpu_ready = r_cpu_ready;
  assign cpu_rdata = r_cpu_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef CACHE_STATS_EN
  logic              r_lookup_hit;
  logic              w_done_hit;
  logic              w_done_miss;
  logic [STAT_W-1:0] r_hit_count;
  logic [STAT_W-1:0] r_miss_count;

  // Classify an access when it completes, so an aborted refill never counts.
  always_comb begin
    w_done_hit  = 1'b0;
    w_done_miss = 1'b0;
    case (r_state)
      LOOKUP: begin
        if (!r_we && w_hit) w_done_hit = 1'b1;
        else                w_done_hit = 1'b0;
      end
      REFILL:    w_done_miss = mem_ack;
      WRITE_MEM: begin
        w_done_hit  = mem_ack & r_lookup_hit;
        w_done_miss = mem_ack & ~r_lookup_hit;
      end
      default: w_done_hit = 1'b0;
    endcase
  end

  // Saturating hit/miss counters; lookup outcome kept for writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lookup_hit <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (r_state == LOOKUP) r_lookup_hit <= w_hit;
      if (w_done_hit && (r_hit_count != STAT_MAX))
        r_hit_count <= r_hit_count + 16'd1;
      if (w_done_miss && (r_miss_count != STAT_MAX))
        r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Testbench for cache_ctrl_2way: external RAM and backing-memory models,
// a table of directed accesses with hand-computed results, and a
// hand-written reset-during-refill sequence.
module tb_cache_ctrl_2way;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  ram_addr;
  logic [31:0] d0_din, d1_din, d0_dout, d1_dout;
  logic        d0_we, d1_we, t0_we, t1_we;
  logic [13:0] t0_din, t1_din, t0_dout, t1_dout;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  logic        init_ram;
  logic [31:0] d0_mem [8];
  logic [31:0] d1_mem [8];
  logic [13:0] t0_mem [8];
  logic [13:0] t1_mem [8];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cache_ctrl_2way dut (
`ifdef CACHE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr),
    .d0_din(d0_din), .d1_din(d1_din), .d0_we(d0_we), .d1_we(d1_we),
    .d0_dout(d0_dout), .d1_dout(d1_dout),
    .t0_din(t0_din), .t1_din(t1_din), .t0_we(t0_we), .t1_we(t1_we),
    .t0_dout(t0_dout), .t1_dout(t1_dout)
  );

  // Cache RAM models: registered read address; set 5 preloaded with the
  // same tag in both ways to exercise the double-hit rule.
  always @(posedge clock) begin
    if (init_ram) begin
      for (int i = 0; i < 8; i++) begin
        d0_mem[i] <= 32'd0;
        d1_mem[i] <= 32'd0;
        t0_mem[i] <= 14'd0;
        t1_mem[i] <= 14'd0;
      end
      t0_mem[5] <= 14'h200A;
      t1_mem[5] <= 14'h200A;
      d0_mem[5] <= 32'h0000AAAA;
      d1_mem[5] <= 32'h0000BBBB;
    end else begin
      if (d0_we) d0_mem[ram_addr] <= d0_din;
      if (d1_we) d1_mem[ram_addr] <= d1_din;
      if (t0_we) t0_mem[ram_addr] <= t0_din;
      if (t1_we) t1_mem[ram_addr] <= t1_din;
    end
    d0_dout <= d0_mem[ram_addr];
    d1_dout <= d1_mem[ram_addr];
    t0_dout <= t0_mem[ram_addr];
    t1_dout <= t1_mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_val;
    logic [31:0] exp_rdata;
    logic        exp_mem;
    int          exp_lat;
    logic [3:0]  exp_we;    // {t1, t0, d1, d0}
    logic [13:0] exp_tdin;
    logic [31:0] exp_ddin;
    logic [2:0]  exp_idx;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [15];

  // Observations of one access.
  int          obs_lat;
  int          obs_we_cycles;
  logic        obs_timeout, obs_mem, obs_mem_we, obs_req_drop, obs_pulse;
  logic [15:0] obs_mem_addr;
  logic [31:0] obs_mem_wdata, obs_rdata, obs_ddin;
  logic [3:0]  obs_we;
  logic [13:0] obs_tdin;
  logic [2:0]  obs_idx;

  // Issue one CPU access, play the backing memory (ack one cycle after
  // mem_req is seen), and record what the DUT did. Called at #1 after an edge.
  task automatic do_access(input logic we, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [31:0] mem_val);
    int   waitc;
    logic acked;
    logic done;
    logic [3:0] we_now;
    obs_lat = 0; obs_we_cycles = 0; obs_timeout = 1'b0; obs_mem = 1'b0;
    obs_mem_we = 1'b0; obs_req_drop = 1'b1; obs_pulse = 1'b1;
    obs_mem_addr = 16'd0; obs_mem_wdata = 32'd0; obs_rdata = 32'd0;
    obs_ddin = 32'd0; obs_we = 4'd0; obs_tdin = 14'd0; obs_idx = 3'd0;
    waitc = 0; acked = 1'b0; done = 1'b0;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    while (!done && obs_lat < 20) begin
      @(posedge clock); #1;
      obs_lat++;
      if (mem_ack) begin
        mem_ack = 1'b0;
        if (mem_req) obs_req_drop = 1'b0;
      end
      if (cpu_ready) begin
        done = 1'b1;
        obs_rdata = cpu_rdata;
      end else if (mem_req) begin
        if (!obs_mem) begin
          obs_mem = 1'b1; obs_mem_we = mem_we;
          obs_mem_addr = mem_addr; obs_mem_wdata = mem_wdata;
        end
        if (!acked) begin
          if (waitc == 1) begin
            mem_ack = 1'b1; mem_rdata = mem_val; acked = 1'b1;
          end
          waitc++;
        end
      end
      #1;
      we_now = {t1_we, t0_we, d1_we, d0_we};
      if (we_now != 4'd0) begin
        obs_we_cycles++;
        obs_we  = obs_we | we_now;
        obs_idx = ram_addr;
        obs_tdin = t0_we ? t0_din : t1_din;
        obs_ddin = d0_we ? d0_din : d1_din;
      end
    end
    if (!done) obs_timeout = 1'b1;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    @(posedge clock); #1;
    if (cpu_ready) obs_pulse = 1'b0;
  endtask

  initial begin
    int exp_hits;
    int exp_misses;
    int waitc;
    exp_hits = 0; exp_misses = 0;
    reset = 1'b1; init_ram = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;

    //            we    addr      wdata         mem_val       exp_rdata     mem  lat we       tdin      ddin          idx  hit
    vecs[0]  = '{1'b0, 16'h0009, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 4, 4'b0101, 14'h2001, 32'hDEADBEEF, 3'd1, 1'b0};
    vecs[1]  = '{1'b0, 16'h0009, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 2, 4'b0000, 14'h0,    32'h0,        3'd0, 1'b1};
    vecs[2]  = '{1'b0, 16'h0011, 32'h0,        32'hA5A50011, 32'hA5A50011, 1'b1, 4, 4'b1010, 14'h2002, 32'hA5A50011, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 16'h0019, 32'h0,        32'h19191919, 32'h19191919, 1'b1, 4, 4'b0101, 14'h2003, 32'h19191919, 3'd1, 1'b0};
    vecs[4]  = '{1'b1, 16'h0011, 32'h12345678, 32'h0,        32'h19191919, 1'b1, 4, 4'b0010, 14'h0,    32'h12345678, 3'd1, 1'b1};
    vecs[5]  = '{1'b0, 16'h0011, 32'h0,        32'h0,        32'h12345678, 1'b0, 2, 4'b0000, 14'h0,    32'h0,        3'd0, 1'b1};
    vecs[6]  = '{1'b0, 16'h0009, 32'h0,        32'hCAFE0009, 32'hCAFE0009, 1'b1, 4, 4'b0101, 14'h2001, 32'hCAFE0009, 3'd1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0019, 32'h0,        32'h0BAD0019, 32'h0BAD0019, 1'b1, 4, 4'b1010, 14'h2003, 32'h0BAD0019, 3'd1, 1'b0};
    vecs[8]  = '{1'b1, 16'h0022, 32'h000055AA, 32'h0,        32'h0BAD0019, 1'b1, 4, 4'b0000, 14'h0,    32'h0,        3'd0, 1'b0};
    vecs[9]  = '{1'b0, 16'h0022, 32'h0,        32'h22222222, 32'h22222222, 1'b1, 4, 4'b0101, 14'h2004, 32'h22222222, 3'd2, 1'b0};
    vecs[10] = '{1'b0, 16'h0009, 32'h0,        32'h0,        32'hCAFE0009, 1'b0, 2, 4'b0000, 14'h0,    32'h0,        3'd0, 1'b1};
    vecs[11] = '{1'b0, 16'hFFFF, 32'h0,        32'hFFFF0000, 32'hFFFF0000, 1'b1, 4, 4'b0101, 14'h3FFF, 32'hFFFF0000, 3'd7, 1'b0};
    vecs[12] = '{1'b0, 16'hFFFF, 32'h0,        32'h0,        32'hFFFF0000, 1'b0, 2, 4'b0000, 14'h0,    32'h0,        3'd0, 1'b1};
    vecs[13] = '{1'b0, 16'h0055, 32'h0,        32'h0,        32'h0000AAAA, 1'b0, 2, 4'b0000, 14'h0,    32'h0,        3'd0, 1'b1};
    vecs[14] = '{1'b0, 16'h005D, 32'h0,        32'h5D5D5D5D, 32'h5D5D5D5D, 1'b1, 4, 4'b1010, 14'h200B, 32'h5D5D5D5D, 3'd5, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0; init_ram = 1'b0;

    check("reset cpu_ready", 32'(cpu_ready), 32'd0);
    check("reset mem_req",   32'(mem_req),   32'd0);
    check("reset mem_we",    32'(mem_we),    32'd0);
    check("reset cpu_rdata", cpu_rdata,      32'd0);
    check("reset mem_addr",  32'(mem_addr),  32'd0);
    check("reset mem_wdata", mem_wdata,      32'd0);
    check("reset ram we",    32'({t1_we, t0_we, d1_we, d0_we}), 32'd0);
`ifdef CACHE_STATS_EN
    check("reset hit_count",  32'(hit_count),  32'd0);
    check("reset miss_count", 32'(miss_count), 32'd0);
`endif

    for (int i = 0; i < 15; i++) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mem_val);
      check($sformatf("v%0d timeout", i), 32'(obs_timeout), 32'd0);
      check($sformatf("v%0d latency", i), 32'(obs_lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d cpu_rdata", i), obs_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d ready pulse", i), 32'(obs_pulse), 32'd1);
      check($sformatf("v%0d mem access", i), 32'(obs_mem), 32'(vecs[i].exp_mem));
      check($sformatf("v%0d ram we set", i), 32'(obs_we), 32'(vecs[i].exp_we));
      check($sformatf("v%0d ram we cycles", i), 32'(obs_we_cycles),
            (vecs[i].exp_we != 4'd0) ? 32'd1 : 32'd0);
      if (vecs[i].exp_we != 4'd0) begin
        check($sformatf("v%0d ram_addr", i), 32'(obs_idx), 32'(vecs[i].exp_idx));
        check($sformatf("v%0d data din", i), obs_ddin, vecs[i].exp_ddin);
      end
      if (vecs[i].exp_we[3:2] != 2'b00)
        check($sformatf("v%0d tag din", i), 32'(obs_tdin), 32'(vecs[i].exp_tdin));
      if (vecs[i].exp_mem) begin
        check($sformatf("v%0d mem_we", i), 32'(obs_mem_we), 32'(vecs[i].we));
        check($sformatf("v%0d mem_addr", i), 32'(obs_mem_addr), 32'(vecs[i].addr));
        check($sformatf("v%0d mem_req drop", i), 32'(obs_req_drop), 32'd1);
        if (vecs[i].we)
          check($sformatf("v%0d mem_wdata", i), obs_mem_wdata, vecs[i].wdata);
      end
      if (vecs[i].exp_hit) exp_hits++;
      else                 exp_misses++;
    end
`ifdef CACHE_STATS_EN
    check("hit_count",  32'(hit_count),  32'(exp_hits));
    check("miss_count", 32'(miss_count), 32'(exp_misses));
`endif

    // Reset while a refill waits for its ack; a late ack must do nothing.
    cpu_we = 1'b0; cpu_addr = 16'h0031; cpu_wdata = 32'd0; cpu_req = 1'b1;
    waitc = 0;
    while (!mem_req && waitc < 10) begin
      @(posedge clock); #1;
      waitc++;
    end
    check("abort mem_req raised", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("abort we during reset", 32'({t1_we, t0_we, d1_we, d0_we}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; cpu_req = 1'b0;
    check("abort mem_req",   32'(mem_req),   32'd0);
    check("abort cpu_ready", 32'(cpu_ready), 32'd0);
    check("abort cpu_rdata", cpu_rdata,      32'd0);
    check("abort mem_addr",  32'(mem_addr),  32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BADBAD0;
    #1;
    check("late ack we", 32'({t1_we, t0_we, d1_we, d0_we}), 32'd0);
    @(posedge clock); #1;
    mem_ack = 1'b0;
    check("late ack cpu_ready", 32'(cpu_ready), 32'd0);
    check("late ack mem_req",   32'(mem_req),   32'd0);
    check("late ack cpu_rdata", cpu_rdata,      32'd0);

    // Cache contents survive reset: 0x0009 still hits in way 0.
    do_access(1'b0, 16'h0009, 32'd0, 32'd0);
    check("post-reset hit latency", 32'(obs_lat), 32'd2);
    check("post-reset hit rdata",   obs_rdata,    32'hCAFE0009);
    check("post-reset hit no mem",  32'(obs_mem), 32'd0);
    // The aborted 0x0031 left no trace: it misses and fills way 1 (LRU).
    do_access(1'b0, 16'h0031, 32'd0, 32'h31313131);
    check("post-reset miss rdata", obs_rdata,       32'h31313131);
    check("post-reset miss we",    32'(obs_we),     32'(4'b1010));
    check("post-reset miss tdin",  32'(obs_tdin),   32'h2006);
`ifdef CACHE_STATS_EN
    check("post-reset hit_count",  32'(hit_count),  32'd1);
    check("post-reset miss_count", 32'(miss_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
